// File: rtl/rr_grant_arbiter.sv
// Registered round-robin arbiter with valid/ready handshake and bounded grant
// locking for multi-beat transfers. The winner is presented as a one-hot grant
// plus its binary index, both driven straight from registers.
module rr_grant_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    parameter int MAX_HOLD       = 8,
    parameter int INDEX_WIDTH    = $clog2(NUM_REQUESTERS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic                      lock,
    input  logic                      grant_ready,
    output logic                      grant_valid,
    output logic [NUM_REQUESTERS-1:0] grant_oh,
    output logic [INDEX_WIDTH-1:0]    grant_idx,
    output logic                      grant_locked
);

    // hold_count spans 0..MAX_HOLD-1; keep at least one bit when MAX_HOLD=1.
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t                    state_q,      state_d;
    logic [NUM_REQUESTERS-1:0] last_grant_q, last_grant_d;
    logic [NUM_REQUESTERS-1:0] grant_oh_q,   grant_oh_d;
    logic [HOLD_W-1:0]         hold_q,       hold_d;
    logic                      locked_q,     locked_d;
    logic                      keep_lock;

    // Round-robin pick: scan upward from the bit above ptr, wrapping, so the
    // pointer's own bit is examined last and therefore has lowest priority.
    function automatic logic [NUM_REQUESTERS-1:0] rr_pick(
        input logic [NUM_REQUESTERS-1:0] req,
        input logic [NUM_REQUESTERS-1:0] ptr
    );
        logic [NUM_REQUESTERS-1:0] res;
        logic                      found;
        int                        base;
        int                        j;
        res   = '0;
        found = 1'b0;
        base  = 0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (ptr[i]) base = i;
        end
        for (int k = 1; k <= NUM_REQUESTERS; k++) begin
            j = (base + k) % NUM_REQUESTERS;
            if (!found && req[j]) begin
                res[j] = 1'b1;
                found  = 1'b1;
            end
        end
        return res;
    endfunction

    // State register: FSM state plus pointer, hold counter and offered grant.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous here, so it lives inside the clocked
        // branch and takes priority over any transfer happening on the same edge.
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= {1'b1, {(NUM_REQUESTERS-1){1'b0}}};
            grant_oh_q   <= '0;
            hold_q       <= '0;
            locked_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the next-state logic.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_oh_q   <= grant_oh_d;
            hold_q       <= hold_d;
            locked_q     <= locked_d;
        end
    end

    // Lock continues only while the granted requester still asks and the cap is not hit.
    assign keep_lock = lock && (|(request & grant_oh_q)) && (int'(hold_q) < MAX_HOLD - 1);

    // Next-state logic: new offer from IDLE, hold while stalled, rotate or lock on transfer.
    always_comb begin
        // NOTE: every target gets a hold-value default first, so no path can
        // leave one unassigned and infer a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_oh_d   = grant_oh_q;
        hold_d       = hold_q;
        locked_d     = locked_q;
        case (state_q)
            IDLE: begin
                if (|request) begin
                    state_d    = OFFER;
                    grant_oh_d = rr_pick(request, last_grant_q);
                    hold_d     = '0;
                    locked_d   = 1'b0;
                end
            end
            OFFER: begin
                if (grant_ready) begin
                    last_grant_d = grant_oh_q;
                    if (keep_lock) begin
                        hold_d   = hold_q + HOLD_W'(1);
                        locked_d = 1'b1;
                    end else begin
                        hold_d   = '0;
                        locked_d = 1'b0;
                        if (|request) begin
                            // The granted bit is now the pointer, so it rotates away.
                            grant_oh_d = rr_pick(request, grant_oh_q);
                        end else begin
                            state_d    = IDLE;
                            grant_oh_d = '0;
                        end
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                grant_oh_d = '0;
                hold_d     = '0;
                locked_d   = 1'b0;
            end
        endcase
    end

    // Outputs decode registered state only; grant_idx ORs indices of the one-hot grant.
    always_comb begin
        grant_valid  = (state_q == OFFER);
        grant_oh     = grant_oh_q;
        grant_locked = locked_q;
        grant_idx    = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (grant_oh_q[i]) grant_idx = grant_idx | INDEX_WIDTH'(i);
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter (4 requesters, MAX_HOLD=3).
module tb_rr_grant_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] request;
    logic       lock;
    logic       grant_ready;
    logic       grant_valid;
    logic [3:0] grant_oh;
    logic [1:0] grant_idx;
    logic       grant_locked;

    int total = 0;
    int bad   = 0;

    rr_grant_arbiter #(
        .NUM_REQUESTERS(4),
        .MAX_HOLD      (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .request     (request),
        .lock        (lock),
        .grant_ready (grant_ready),
        .grant_valid (grant_valid),
        .grant_oh    (grant_oh),
        .grant_idx   (grant_idx),
        .grant_locked(grant_locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs reflect that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the full offer: valid, one-hot, index and lock flag.
    task automatic expect_offer(input string tag, input int idx, input logic locked);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        check({tag, ".valid"},  32'(grant_valid),  32'd1);
        check({tag, ".oh"},     32'(grant_oh),     32'(oh));
        check({tag, ".idx"},    32'(grant_idx),    32'(idx));
        check({tag, ".locked"}, 32'(grant_locked), 32'(locked));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".valid"},  32'(grant_valid),  32'd0);
        check({tag, ".oh"},     32'(grant_oh),     32'd0);
        check({tag, ".idx"},    32'(grant_idx),    32'd0);
        check({tag, ".locked"}, 32'(grant_locked), 32'd0);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        request     = 4'b0000;
        lock        = 1'b0;
        grant_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int rr_exp[5];
        rr_exp = '{0, 1, 2, 3, 0};

        // Reset state.
        do_reset();
        expect_idle("reset");
        step();
        expect_idle("idle_no_req");

        // Full request set rotates 0,1,2,3,0; first offer 1 cycle after request.
        request     = 4'b1111;
        grant_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_offer($sformatf("rr%0d", i), rr_exp[i], 1'b0);
        end

        // Stall: offer stays 0001 for 4 cycles, then rotates to 0100.
        do_reset();
        request     = 4'b0101;
        grant_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_offer($sformatf("stall%0d", i), 0, 1'b0);
            if (i == 3) grant_ready = 1'b1;
        end
        step();
        expect_offer("stall_next", 2, 1'b0);

        // Lock with MAX_HOLD=3: idx 0 three times (locked 0,1,1), then idx 3.
        do_reset();
        request     = 4'b1001;
        lock        = 1'b1;
        grant_ready = 1'b1;
        step();
        expect_offer("lock0", 0, 1'b0);
        step();
        expect_offer("lock1", 0, 1'b1);
        step();
        expect_offer("lock2", 0, 1'b1);
        step();
        expect_offer("lock_cap", 3, 1'b0);

        // Locked requester withdraws: next offer is idx 1, unlocked.
        do_reset();
        request     = 4'b0100;
        lock        = 1'b1;
        grant_ready = 1'b1;
        step();
        expect_offer("drop0", 2, 1'b0);
        step();
        expect_offer("drop1", 2, 1'b1);
        request = 4'b0010;
        step();
        expect_offer("drop_next", 1, 1'b0);

        // Reset during a locked offer drops it; priority restarts at 0.
        do_reset();
        request     = 4'b1000;
        lock        = 1'b1;
        grant_ready = 1'b1;
        step();
        expect_offer("rst_lk0", 3, 1'b0);
        step();
        expect_offer("rst_lk1", 3, 1'b1);
        reset = 1'b1;
        step();
        expect_idle("rst_mid");
        reset   = 1'b0;
        request = 4'b1111;
        lock    = 1'b0;
        step();
        expect_offer("rst_first", 0, 1'b0);

        // Single requester: regranted every cycle, no bubbles.
        do_reset();
        request     = 4'b0010;
        grant_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_offer($sformatf("single%0d", i), 1, 1'b0);
        end

        // Requests drop after a transfer: back to idle.
        request = 4'b0000;
        step();
        expect_idle("to_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
